// File: rtl/modexp_sequencer.sv
// modexp_sequencer: orders square/multiply ops for left-to-right
// modular exponentiation over a shared modmul unit.
module modexp_sequencer #(
  parameter int E_WIDTH = 16
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic [E_WIDTH-1:0] exponent,
  input  logic               mm_done,
  output logic               acc_init,
  output logic               mm_start,
  output logic               mm_op,
  output logic               busy,
  output logic               done
);

  localparam int IW = (E_WIDTH > 1) ? $clog2(E_WIDTH) : 1;
  localparam logic [IW-1:0] TOP = IW'(E_WIDTH - 1);

  typedef enum logic [3:0] {
    S_IDLE,
    S_INIT,
    S_BIT,
    S_SQ_ISSUE,
    S_SQ_WAIT,
    S_MUL_ISSUE,
    S_MUL_WAIT,
    S_NEXT,
    S_DONE
  } state_t;

  state_t             state, state_nx;
  logic [E_WIDTH-1:0] e_reg, e_nx;
  logic [IW-1:0]      idx, idx_nx;
  logic               first, first_nx;
  logic               cur_bit;

  assign cur_bit = e_reg[idx];

  // State and walk registers; reset abandons any outstanding op.
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= S_IDLE;
      e_reg <= '0;
      idx   <= '0;
      first <= 1'b0;
    end else begin
      state <= state_nx;
      e_reg <= e_nx;
      idx   <= idx_nx;
      first <= first_nx;
    end
  end

  // Next-state logic: MSB-first walk, square skipped while acc is 1.
  always_comb begin
    state_nx = state;
    e_nx     = e_reg;
    idx_nx   = idx;
    first_nx = first;
    case (state)
      S_IDLE: begin
        if (start) begin
          e_nx     = exponent;
          idx_nx   = TOP;
          first_nx = 1'b1;
          state_nx = S_INIT;
        end
      end
      S_INIT: begin
        if (e_reg == '0) state_nx = S_DONE;
        else             state_nx = S_BIT;
      end
      S_BIT: begin
        if (!first)       state_nx = S_SQ_ISSUE;
        else if (cur_bit) state_nx = S_MUL_ISSUE;
        else              state_nx = S_NEXT;
      end
      S_SQ_ISSUE: state_nx = S_SQ_WAIT;
      S_SQ_WAIT: begin
        if (mm_done) begin
          if (cur_bit) state_nx = S_MUL_ISSUE;
          else         state_nx = S_NEXT;
        end
      end
      S_MUL_ISSUE: begin
        first_nx = 1'b0;
        state_nx = S_MUL_WAIT;
      end
      S_MUL_WAIT: begin
        if (mm_done) state_nx = S_NEXT;
      end
      S_NEXT: begin
        if (idx == '0) begin
          state_nx = S_DONE;
        end else begin
          idx_nx   = idx - 1'b1;
          state_nx = S_BIT;
        end
      end
      S_DONE:  state_nx = S_IDLE;
      default: state_nx = S_IDLE;
    endcase
  end

  // Moore outputs decoded from the registered state only.
  always_comb begin
    acc_init = 1'b0;
    mm_start = 1'b0;
    mm_op    = 1'b0;
    busy     = (state != S_IDLE);
    done     = 1'b0;
    case (state)
      S_INIT:      acc_init = 1'b1;
      S_SQ_ISSUE:  mm_start = 1'b1;
      S_MUL_ISSUE: begin
        mm_start = 1'b1;
        mm_op    = 1'b1;
      end
      S_MUL_WAIT:  mm_op = 1'b1;
      S_DONE:      done = 1'b1;
      default:     ;
    endcase
  end

endmodule

// File: tb/tb_modexp_sequencer.sv
// tb_modexp_sequencer: directed and random exponent runs checked
// against an arithmetic square-and-multiply op-sequence model.
module tb_modexp_sequencer;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic [15:0] exponent;
  logic        mm_done;
  logic        acc_init;
  logic        mm_start;
  logic        mm_op;
  logic        busy;
  logic        done;

  int total = 0;
  int bad   = 0;

  modexp_sequencer #(.E_WIDTH(16)) dut (
    .clk      (clk),
    .rst      (rst),
    .start    (start),
    .exponent (exponent),
    .mm_done  (mm_done),
    .acc_init (acc_init),
    .mm_start (mm_start),
    .mm_op    (mm_op),
    .busy     (busy),
    .done     (done)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs,
                     input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_quiet(input string tag);
    chk({tag, "_acc_init"}, acc_init, 0);
    chk({tag, "_mm_start"}, mm_start, 0);
    chk({tag, "_mm_op"}, mm_op, 0);
    chk({tag, "_busy"}, busy, 0);
    chk({tag, "_done"}, done, 0);
  endtask

  // One exponentiation: model the op list, play the modmul unit with
  // random latency, optionally inject noise, a mid-run start or a reset.
  task automatic run(input logic [15:0] e, input int maxd,
                     input bit noise, input bit restart, input bit abort);
    logic [63:0] wb, gb;
    int wl, gl, m, eb, bn, an, dn, cnt;
    bit out, cop, late, fin, hit;
    wb = 0; wl = 0; m = -1;
    for (int i = 15; i >= 0; i--)
      if (e[i] && m < 0) m = i;
    if (m >= 0) begin
      wb = 1; wl = 1;
      for (int i = m - 1; i >= 0; i--) begin
        wb = {wb[62:0], 1'b0}; wl++;
        if (e[i]) begin
          wb = {wb[62:0], 1'b1}; wl++;
        end
      end
    end
    eb = (m < 0) ? 2 : 2 + 2 * 16;
    gb = 0; gl = 0; bn = 0; an = 0; dn = 0; cnt = 0;
    out = 0; cop = 0; late = 0; fin = 0; hit = 0;
    start = 1; exponent = e; mm_done = 0;
    @(negedge clk);
    start = 0; exponent = 16'($urandom);
    chk("start_busy", busy, 1);
    chk("start_acc_init", acc_init, 1);
    for (int cyc = 0; cyc < 2000 && !fin; cyc++) begin
      mm_done = 0; start = 0;
      if (abort && out && cop == 1'b0) begin
        hit = 1;
        break;
      end
      if (busy) bn++;
      if (acc_init) begin
        an++;
        if (gl != 0) late = 1;
      end
      if (done) begin
        dn++;
        fin = 1;
      end
      if (out) begin
        chk("op_stable", mm_op, cop);
        chk("no_overlap", mm_start, 0);
        if (cnt == 0) begin
          mm_done = 1; out = 0;
        end else begin
          cnt--;
        end
      end else if (mm_start) begin
        gb = {gb[62:0], mm_op}; gl++;
        cop = mm_op;
        cnt = $urandom_range(maxd, 0);
        eb += 2 + cnt;
        out = 1;
        if (noise) mm_done = 1'($urandom);
      end else if (noise) begin
        mm_done = 1'($urandom);
      end
      if (restart && cyc == 4) begin
        start = 1; exponent = ~e;
      end
      if (!fin) @(negedge clk);
    end
    if (hit) begin
      rst = 1; mm_done = 0; start = 0;
      @(negedge clk);
      chk_quiet("rst_mid");
      rst = 0;
      @(negedge clk);
      chk("rst_after_busy", busy, 0);
      chk("rst_after_done", done, 0);
      return;
    end
    chk("finished", fin, 1);
    chk("op_count", gl, wl);
    chk("op_seq", gb, wb);
    chk("acc_init_count", an, 1);
    chk("acc_init_late", late, 0);
    chk("done_count", dn, 1);
    chk("busy_cycles", bn, eb);
    @(negedge clk);
    mm_done = 0;
    chk("after_busy", busy, 0);
    chk("after_done", done, 0);
  endtask

  initial begin
    rst = 1; start = 0; exponent = 0; mm_done = 0;
    repeat (3) @(negedge clk);
    chk_quiet("reset");
    rst = 0;
    @(negedge clk);
    chk_quiet("idle");
    run(16'h000B, 0, 0, 0, 0);
    run(16'h0000, 0, 0, 0, 0);
    run(16'h8000, 0, 0, 0, 0);
    run(16'h0001, 0, 0, 0, 0);
    run(16'hFFFF, 0, 0, 0, 0);
    repeat (2) @(negedge clk);
    run(16'h000B, 7, 1, 0, 0);
    for (int k = 0; k < 10; k++)
      run(16'($urandom), 7, 1, k[0], 0);
    run(16'hA5C3, 3, 1, 1, 0);
    repeat (3) @(negedge clk);
    run(16'h000B, 0, 0, 0, 1);
    run(16'h000B, 0, 0, 0, 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
